// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline sequencing controller for the five-stage MIPS core.
//            Generates the PC / pipeline-buffer load enables and the
//            flush/bubble selects. Resolves load-use hazards, taken-branch
//            squashes and data-memory wait states. Traps a memory access
//            that never completes, and counts stall cycles.
// Ports    : clock, reset        - clock, asynchronous active-high reset
//            id_rs, id_rt        - source fields of the instruction in ID
//            id_uses_rt          - ID instruction reads rt
//            ex_dest             - destination register of the EX instruction
//            ex_mem_read         - EX instruction is a load
//            branch_taken        - EX resolved a taken branch/jump this cycle
//            mem_req, mem_ready  - MEM stage access request / completion
//            pc_load, load1..4   - load enables: PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//            flush1              - NOP into IF/ID
//            bubble2, bubble4    - zero the control inputs of ID/EX, MEM/WB
//            mem_error           - sticky memory-timeout trap
//            stall_cycles        - saturating count of cycles with pc_load=0
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rt,
  input  logic [4:0]           ex_dest,
  input  logic                 ex_mem_read,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_load,
  output logic                 load1,
  output logic                 load2,
  output logic                 load3,
  output logic                 load4,
  output logic                 flush1,
  output logic                 bubble2,
  output logic                 bubble4,
  output logic                 mem_error,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  // The wait counter holds the number of stall cycles already completed
  // while in MEM_WAIT. Trapping once it reaches MEM_TIMEOUT-1 makes the
  // edge ending the MEM_TIMEOUT-th consecutive stall cycle enter ERROR.
  // RUN always passes through MEM_WAIT first, so MEM_TIMEOUT=1 traps on
  // the second consecutive stall cycle.
  localparam logic [15:0] c_WAIT_LIMIT = 16'(MEM_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [15:0]           r_wait_cnt;
  logic [15:0]           w_wait_next;
  logic                  r_mem_error;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;

  logic                  w_memstall;
  logic                  w_luse;
  // {pc_load, load1, load2, load3, load4, flush1, bubble2, bubble4}
  logic [7:0]            w_ctl;

  assign w_memstall = mem_req & ~mem_ready;
  assign w_luse     = ex_mem_read & (ex_dest != 5'd0) &
                      ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    w_ctl        = 8'b0000_0000;
    case (r_state)
      RUN, MEM_WAIT: begin
        if (w_memstall) begin
          // Freeze the front of the pipe, let MEM/WB drain with a bubble.
          w_ctl = 8'b0000_1001;
          if (r_state == RUN) begin
            w_state_next = MEM_WAIT;
            w_wait_next  = 16'd1;
          end else if (r_wait_cnt >= c_WAIT_LIMIT) begin
            w_state_next = ERROR;
          end else begin
            w_wait_next = r_wait_cnt + 16'd1;
          end
        end else begin
          // Release cycle shares the RUN priorities, so a pending branch or
          // load-use is serviced immediately.
          w_state_next = RUN;
          w_wait_next  = 16'd0;
          if (branch_taken) begin
            w_ctl = 8'b1111_1110;      // squashed ID instruction hides luse
          end else if (w_luse) begin
            w_ctl = 8'b0011_1010;
          end else begin
            w_ctl = 8'b1111_1000;
          end
        end
      end
      ERROR: begin
        w_ctl = 8'b0000_0000;
      end
      default: begin
        w_state_next = RUN;
        w_wait_next  = 16'd0;
      end
    endcase
  end

  // Outputs are forced inactive while reset is held.
  assign {pc_load, load1, load2, load3, load4, flush1, bubble2, bubble4} =
         reset ? 8'b0000_0000 : w_ctl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_error <= 1'b0;
    end else if (w_state_next == ERROR) begin
      r_mem_error <= 1'b1;
    end
  end

  // Frozen ERROR cycles are not counted; the count saturates at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state != ERROR) && !w_ctl[7] && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign mem_error    = r_mem_error;
  assign stall_cycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. Main instance uses
//            MEM_TIMEOUT=4; a second instance with CNT_WIDTH=2 shares the
//            stimulus to observe counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_dest;
  logic        id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;

  logic        pc_load, load1, load2, load3, load4, flush1, bubble2, bubble4;
  logic        mem_error;
  logic [31:0] stall_cycles;

  logic        s_pc_load, s_load1, s_load2, s_load3, s_load4;
  logic        s_flush1, s_bubble2, s_bubble4, s_mem_error;
  logic [1:0]  s_stall;

  always #5 clock = ~clock;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) u_dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_load(pc_load), .load1(load1), .load2(load2), .load3(load3), .load4(load4),
    .flush1(flush1), .bubble2(bubble2), .bubble4(bubble4),
    .mem_error(mem_error), .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.MEM_TIMEOUT(255), .CNT_WIDTH(2)) u_sat (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_load(s_pc_load), .load1(s_load1), .load2(s_load2), .load3(s_load3),
    .load4(s_load4), .flush1(s_flush1), .bubble2(s_bubble2), .bubble4(s_bubble4),
    .mem_error(s_mem_error), .stall_cycles(s_stall)
  );

  // Expected control word: {pc_load, load1, load2, load3, load4, flush1, bubble2, bubble4}
  localparam logic [7:0] NRM = 8'hF8;  // all loads, no bubbles
  localparam logic [7:0] MST = 8'h09;  // memory stall
  localparam logic [7:0] BRN = 8'hFE;  // taken branch
  localparam logic [7:0] LUS = 8'h3A;  // load-use
  localparam logic [7:0] ZER = 8'h00;  // frozen / reset

  typedef struct {
    logic [4:0] rs, rt, dest;
    logic       uses_rt, rd, br, req, rdy;
    logic [7:0] ctl;
    logic       err;
  } vec_t;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_stall;
  logic [1:0]  exp_sat;
  logic [7:0]  exp_q[$];
  vec_t        tbl[18];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic uses_rt, input logic [4:0] dest,
                              input logic rd, input logic br, input logic req,
                              input logic rdy, input logic [7:0] ctl,
                              input logic err);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.dest = dest; v.rd = rd;
    v.br = br; v.req = req; v.rdy = rdy; v.ctl = ctl; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; ex_dest = v.dest;
    ex_mem_read = v.rd; branch_taken = v.br; mem_req = v.req; mem_ready = v.rdy;
  endtask

  // One full cycle: drive, sample controls mid-cycle, check registered state
  // just after the closing edge.
  task automatic apply(input vec_t v);
    logic [7:0] got;
    drive(v);
    exp_q.push_back(v.ctl);
    @(negedge clock);
    got = {pc_load, load1, load2, load3, load4, flush1, bubble2, bubble4};
    check("ctl", {24'd0, got}, {24'd0, exp_q.pop_front()});
    // A counted stall is any cycle with pc_load low outside the frozen state.
    if (!v.ctl[7] && v.ctl != ZER) begin
      exp_stall++;
      if (exp_sat != 2'd3) exp_sat++;
    end
    @(posedge clock);
    #1;
    check("stall_cycles", stall_cycles, exp_stall);
    check("sat_stall", {30'd0, s_stall}, {30'd0, exp_sat});
    check("mem_error", {31'd0, mem_error}, {31'd0, v.err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [7:0] got;
    //            rs    rt    urt dest  rd br req rdy ctl  err
    tbl[0]  = mk(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NRM, 0);
    tbl[1]  = mk(5'd5, 5'd2, 0, 5'd5, 1, 0, 0, 0, LUS, 0);
    tbl[2]  = mk(5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, NRM, 0); // dest r0: no hazard
    tbl[3]  = mk(5'd1, 5'd7, 1, 5'd7, 1, 0, 0, 0, LUS, 0); // rt match
    tbl[4]  = mk(5'd1, 5'd7, 0, 5'd7, 1, 0, 0, 0, NRM, 0); // rt not read
    tbl[5]  = mk(5'd5, 5'd0, 0, 5'd5, 0, 0, 0, 0, NRM, 0); // not a load
    tbl[6]  = mk(5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 0, BRN, 0); // branch + luse
    tbl[7]  = mk(5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, BRN, 0);
    tbl[8]  = mk(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, MST, 0); // 3-cycle wait
    tbl[9]  = mk(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, MST, 0);
    tbl[10] = mk(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, MST, 0);
    tbl[11] = mk(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, NRM, 0); // release
    tbl[12] = mk(5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, MST, 0); // branch held
    tbl[13] = mk(5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, MST, 0);
    tbl[14] = mk(5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, BRN, 0); // release w/ branch
    tbl[15] = mk(5'd9, 5'd0, 0, 5'd9, 1, 0, 1, 0, MST, 0); // stall beats luse
    tbl[16] = mk(5'd9, 5'd0, 0, 5'd9, 1, 0, 1, 1, LUS, 0); // release w/ luse
    tbl[17] = mk(5'd3, 5'd4, 1, 5'd6, 1, 0, 0, 1, NRM, 0);

    // Reset state
    reset = 1'b1;
    drive(mk(5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 0, ZER, 0));
    exp_stall = 32'd0;
    exp_sat   = 2'd0;
    #12;
    got = {pc_load, load1, load2, load3, load4, flush1, bubble2, bubble4};
    check("reset_ctl", {24'd0, got}, {24'd0, ZER});
    check("reset_stall", stall_cycles, 32'd0);
    check("reset_err", {31'd0, mem_error}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 18; i++) apply(tbl[i]);

    // Reset asserted asynchronously in cycle 2 of a memory wait.
    v = mk(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, MST, 0);
    apply(v);
    drive(v);
    #2;
    reset = 1'b1;
    #1;
    got = {pc_load, load1, load2, load3, load4, flush1, bubble2, bubble4};
    check("rst_mid_ctl", {24'd0, got}, {24'd0, ZER});
    check("rst_mid_stall", stall_cycles, 32'd0);
    check("rst_mid_sat", {30'd0, s_stall}, 32'd0);
    check("rst_mid_err", {31'd0, mem_error}, 32'd0);
    exp_stall = 32'd0;
    exp_sat   = 2'd0;
    @(posedge clock);
    #3;
    reset = 1'b0;
    apply(mk(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NRM, 0));

    // Timeout: four consecutive stalls, then frozen regardless of inputs.
    for (int i = 0; i < 3; i++) apply(mk(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, MST, 0));
    apply(mk(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, MST, 1));
    check("timeout_stall", stall_cycles, 32'd4);
    apply(mk(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, ZER, 1));
    apply(mk(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, ZER, 1));
    apply(mk(5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, ZER, 1));
    apply(mk(5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 0, ZER, 1));
    apply(mk(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, ZER, 1));
    check("frozen_stall", stall_cycles, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
